pingpong_rd_ctrl: RTL

- Read-side controller for the ping-pong buffer. It drains the two RAM banks (A, B) that the ping-pong writer fills.
- Waits for a bank's full flag, then reads all DEPTH words from that bank through its 1-cycle-latency read port and presents them as one continuous stream with valid/ready backpressure.
- When the bank has been read out, pulses that bank's release so the writer can refill it.
- Banks are consumed strictly A, B, A, B, ...

---
 rtl/pingpong_rd_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/pingpong_rd_ctrl.sv
// Ping-pong buffer read controller: drains banks A/B alternately into a 2-entry skid FIFO.
// Optional `PP_RD_LAST_EN adds dout_last, flagging the final word of each bank.
module pingpong_rd_ctrl #(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk_100,
   input  logic              rst,
   input  logic              start,
   input  logic              full_a,
   input  logic              full_b,
   output logic              enb_a,
   output logic [ADDR_W-1:0] addrb_a,
   input  logic [DATA_W-1:0] douta_b,
   output logic              enb_b,
   output logic [ADDR_W-1:0] addrb_b,
   input  logic [DATA_W-1:0] doutb_b,
   output logic              release_a,
   output logic              release_b,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              busy
`ifdef PP_RD_LAST_EN
   ,
   output logic              dout_last
`endif
);

   typedef enum logic [2:0] {IDLE, WAIT_A, RD_A, WAIT_B, RD_B} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            state, next_state;
   logic              armed;
   logic [ADDR_W-1:0] addr_a, addr_b;
   logic              inflight, inflight_b;
   logic [DATA_W-1:0] mem [2];
   logic [1:0]        count;
   logic              rd_ptr, wr_ptr;
   logic              pop, push, issue_ok;
   logic              last_a, last_b, enter_a, enter_b;
   logic [2:0]        occ;
   logic [DATA_W-1:0] rd_data;

   always_comb begin
      pop        = (count != 2'd0) && dout_ready;
      push       = inflight;
      // Occupancy the FIFO will hold once this cycle's push/pop settle.
      occ        = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
      issue_ok   = (occ < 3'd2);
      enb_a      = (state == RD_A) && issue_ok;
      enb_b      = (state == RD_B) && issue_ok;
      last_a     = (addr_a == LAST_ADDR);
      last_b     = (addr_b == LAST_ADDR);
      rd_data    = inflight_b ? doutb_b : douta_b;
      next_state = state;
      case (state)
         IDLE:    if (armed) next_state = WAIT_A;
         WAIT_A:  if (full_a) next_state = RD_A;
         RD_A:    if (enb_a && last_a) next_state = full_b ? RD_B : WAIT_B;
         WAIT_B:  if (full_b) next_state = RD_B;
         RD_B:    if (enb_b && last_b) next_state = full_a ? RD_A : WAIT_A;
         default: next_state = IDLE;
      endcase
      enter_a    = (next_state == RD_A) && (state != RD_A);
      enter_b    = (next_state == RD_B) && (state != RD_B);
   end

   always_ff @(posedge clk_100) begin
      if (rst) begin
         state      <= IDLE;
         armed      <= 1'b0;
         addr_a     <= '0;
         addr_b     <= '0;
         inflight   <= 1'b0;
         inflight_b <= 1'b0;
         release_a  <= 1'b0;
         release_b  <= 1'b0;
         count      <= 2'd0;
         rd_ptr     <= 1'b0;
         wr_ptr     <= 1'b0;
      end else begin
         state      <= next_state;
         armed      <= armed | start;
         if (enter_a)
            addr_a <= '0;
         else if (enb_a && !last_a)
            addr_a <= addr_a + 1'b1;
         if (enter_b)
            addr_b <= '0;
         else if (enb_b && !last_b)
            addr_b <= addr_b + 1'b1;
         inflight   <= enb_a | enb_b;
         inflight_b <= enb_b;
         release_a  <= enb_a && last_a;
         release_b  <= enb_b && last_b;
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         if (push && !pop)
            count <= count + 2'd1;
         else if (!push && pop)
            count <= count - 2'd1;
      end
   end

   always_ff @(posedge clk_100) begin
      if (push) mem[wr_ptr] <= rd_data;
   end

   assign addrb_a    = addr_a;
   assign addrb_b    = addr_b;
   assign dout_valid = (count != 2'd0);
   assign dout       = dout_valid ? mem[rd_ptr] : '0;
   assign busy       = (state == RD_A) || (state == RD_B);

`ifdef PP_RD_LAST_EN
   logic inflight_last;
   logic last_mem [2];

   always_ff @(posedge clk_100) begin
      if (rst)
         inflight_last <= 1'b0;
      else
         inflight_last <= (enb_a && last_a) || (enb_b && last_b);
   end

   always_ff @(posedge clk_100) begin
      if (push) last_mem[wr_ptr] <= inflight_last;
   end

   assign dout_last = dout_valid && last_mem[rd_ptr];
`endif

endmodule
